// File: rtl/stbuf_tcm_master_if.sv
// rtl/stbuf_tcm_master_if.sv - store, load and TCM store-buffer port bundle
interface stbuf_tcm_master_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_DATA_WIDTH = 32,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int SIZE_WIDTH     = 3
);
  logic                      st_valid;
  logic                      st_ready;
  logic [ADDR_WIDTH-1:0]     st_addr;
  logic [SIZE_WIDTH-1:0]     st_size;
  logic [REG_DATA_WIDTH-1:0] st_data;
  logic                      empty;
  logic                      ld_valid;
  logic [ADDR_WIDTH-1:0]     ld_addr;
  logic [SIZE_WIDTH-1:0]     ld_size;
  logic                      ld_data_valid;
  logic [REG_DATA_WIDTH-1:0] ld_data;
  logic [ADDR_WIDTH-1:0]     stbuf_bus_write_addr;
  logic [SIZE_WIDTH-1:0]     stbuf_bus_write_size;
  logic [REG_DATA_WIDTH-1:0] stbuf_bus_write_data;
  logic                      stbuf_bus_wr;
  logic                      bus_stbuf_write_ready;
  logic [ADDR_WIDTH-1:0]     stbuf_bus_read_addr;
  logic [SIZE_WIDTH-1:0]     stbuf_bus_read_size;
  logic                      stbuf_bus_rd;
  logic [BUS_DATA_WIDTH-1:0] bus_stbuf_data;

  modport master (
    input  st_valid, st_addr, st_size, st_data, ld_valid, ld_addr, ld_size,
           bus_stbuf_write_ready, bus_stbuf_data,
    output st_ready, empty, ld_data_valid, ld_data, stbuf_bus_write_addr,
           stbuf_bus_write_size, stbuf_bus_write_data, stbuf_bus_wr,
           stbuf_bus_read_addr, stbuf_bus_read_size, stbuf_bus_rd
  );

  modport slave (
    output st_valid, st_addr, st_size, st_data, ld_valid, ld_addr, ld_size,
           bus_stbuf_write_ready, bus_stbuf_data,
    input  st_ready, empty, ld_data_valid, ld_data, stbuf_bus_write_addr,
           stbuf_bus_write_size, stbuf_bus_write_data, stbuf_bus_wr,
           stbuf_bus_read_addr, stbuf_bus_read_size, stbuf_bus_rd
  );
endinterface

// File: rtl/stbuf_tcm_master.sv
// rtl/stbuf_tcm_master.sv - in-order store buffer draining to the TCM write port,
// with per-byte forwarding of pending stores into TCM load data.
module stbuf_tcm_master #(
  parameter int DEPTH          = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_DATA_WIDTH = 32,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int SIZE_WIDTH     = 3
) (
  input  logic               clk,
  input  logic               rst,
  stbuf_tcm_master_if.master bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int NB = REG_DATA_WIDTH / 8;
  localparam int BW = $clog2(NB);

  logic [PW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]     ent_addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0]     ent_addr_d [DEPTH];
  logic [SIZE_WIDTH-1:0]     ent_size_q [DEPTH];
  logic [SIZE_WIDTH-1:0]     ent_size_d [DEPTH];
  logic [REG_DATA_WIDTH-1:0] ent_data_q [DEPTH];
  logic [REG_DATA_WIDTH-1:0] ent_data_d [DEPTH];
  logic                      ld_valid_q, ld_valid_d;
  logic [SIZE_WIDTH-1:0]     ld_size_q, ld_size_d;
  logic [NB-1:0]             hit_q, hit_d;
  logic [REG_DATA_WIDTH-1:0] fwd_q, fwd_d;

  logic [IW-1:0]             rd_idx, wr_idx, slot;
  logic [PW-1:0]             count;
  logic                      full, empty, size_ok, push, pop;
  logic [ADDR_WIDTH-1:0]     byte_addr, diff;
  logic [REG_DATA_WIDTH-1:0] slot_data, ld_data_c;

  assign rd_idx  = rd_ptr_q[IW-1:0];
  assign wr_idx  = wr_ptr_q[IW-1:0];
  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (rd_ptr_q[IW] != wr_ptr_q[IW]) && (rd_idx == wr_idx);
  assign empty   = (rd_ptr_q == wr_ptr_q);
  assign size_ok = (bus.st_size == SIZE_WIDTH'(1)) || (bus.st_size == SIZE_WIDTH'(2)) ||
                   (bus.st_size == SIZE_WIDTH'(4));
  // Odd sizes still see st_ready high; they are simply never written.
  assign push    = bus.st_valid && !full && size_ok;
  assign pop     = !empty && bus.bus_stbuf_write_ready;

  always_comb begin : fifo_next
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    ent_addr_d = ent_addr_q;
    ent_size_d = ent_size_q;
    ent_data_d = ent_data_q;
    if (push) begin
      ent_addr_d[wr_idx] = bus.st_addr;
      ent_size_d[wr_idx] = bus.st_size;
      ent_data_d[wr_idx] = bus.st_data;
    end
  end

  // Oldest-to-youngest scan so the last matching entry overrides earlier ones.
  // The head being popped this cycle is skipped: the TCM merges that write itself.
  always_comb begin : fwd_scan
    hit_d      = '0;
    fwd_d      = '0;
    byte_addr  = '0;
    diff       = '0;
    slot       = '0;
    slot_data  = '0;
    ld_valid_d = bus.ld_valid;
    ld_size_d  = bus.ld_size;
    for (int unsigned k = 0; k < NB; k++) begin
      byte_addr = bus.ld_addr + ADDR_WIDTH'(k);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot      = rd_idx + IW'(i);
        diff      = byte_addr - ent_addr_q[slot];
        slot_data = ent_data_q[slot] >> {diff[BW-1:0], 3'b000};
        if (bus.ld_valid && (k < 32'(bus.ld_size)) && (PW'(i) < count) &&
            !(pop && (i == 0)) && (diff < ADDR_WIDTH'(ent_size_q[slot])) &&
            (diff < ADDR_WIDTH'(NB))) begin
          hit_d[k]        = 1'b1;
          fwd_d[8*k +: 8] = slot_data[7:0];
        end
      end
    end
  end

  always_comb begin : ld_merge
    ld_data_c = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (ld_valid_q && (k < 32'(ld_size_q))) begin
        ld_data_c[8*k +: 8] = hit_q[k] ? fwd_q[8*k +: 8] : bus.bus_stbuf_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      ld_valid_q <= 1'b0;
      ld_size_q  <= '0;
      hit_q      <= '0;
      fwd_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_size_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      ld_valid_q <= ld_valid_d;
      ld_size_q  <= ld_size_d;
      hit_q      <= hit_d;
      fwd_q      <= fwd_d;
      ent_addr_q <= ent_addr_d;
      ent_size_q <= ent_size_d;
      ent_data_q <= ent_data_d;
    end
  end

  assign bus.st_ready             = !full;
  assign bus.empty                = empty;
  assign bus.stbuf_bus_wr         = !empty;
  assign bus.stbuf_bus_write_addr = empty ? '0 : ent_addr_q[rd_idx];
  assign bus.stbuf_bus_write_size = empty ? '0 : ent_size_q[rd_idx];
  assign bus.stbuf_bus_write_data = empty ? '0 : ent_data_q[rd_idx];
  assign bus.stbuf_bus_read_addr  = bus.ld_addr;
  assign bus.stbuf_bus_read_size  = bus.ld_size;
  assign bus.stbuf_bus_rd         = bus.ld_valid & !rst;
  assign bus.ld_data_valid        = ld_valid_q;
  assign bus.ld_data              = ld_data_c;
endmodule
